// File: rtl/fp_rnd_pipe.sv
`timescale 1ns/1ps
// fp_rnd_pipe
//   Rounding and packing stage that sits after the int->float conversion path.
//   It takes an unpacked value {sign, biased exponent, mantissa, guard/round/
//   sticky, special-case qualifiers} and produces a packed IEEE result:
//   single precision NaN-boxed into 64 bits, or double precision.
//   The stage is a two-deep valid/ready pipeline with latency 2 and a
//   throughput of one transaction per cycle.
//
//   Stage 1 decides the rounding increment and adds it to the mantissa.
//   Stage 2 renormalises, detects overflow/underflow, resolves special cases
//   and packs the result together with the exception flags.
//
// Parameters
//   TAG_W     width of the opaque tag returned unchanged with each result
//
// Ports
//   iClk, iRst                  clock, asynchronous active-high reset
//   iValid / oReady             input handshake
//   iTag                        transaction tag
//   iSig, iExpo, iMant          sign, biased exponent (14b), mantissa (54b)
//   iFmt                        0 single, 1 double, 2/3 handled as single
//   iRm                         0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, 5-7 as RNE
//   iGrs                        guard, round, sticky bits
//   iSnan, iQnan, iDbz, iInfs, iZero   special-case qualifiers
//   oValid / iReady             output handshake
//   oTag, oResult, oFlags       tag, packed result, {NV,DZ,OF,UF,NX}
//
// Build option
//   FP_RND_FLAG_ACC_EN  adds iFlagClr / oFlagAcc: a sticky OR of oFlags over
//                       every output transfer, cleared by iFlagClr.
module fp_rnd_pipe #(
   parameter int TAG_W = 4
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iValid,
   output logic             oReady,
   input  logic [TAG_W-1:0] iTag,
   input  logic             iSig,
   input  logic [13:0]      iExpo,
   input  logic [53:0]      iMant,
   input  logic [1:0]       iFmt,
   input  logic [2:0]       iRm,
   input  logic [2:0]       iGrs,
   input  logic             iSnan,
   input  logic             iQnan,
   input  logic             iDbz,
   input  logic             iInfs,
   input  logic             iZero,
   output logic             oValid,
   input  logic             iReady,
   output logic [TAG_W-1:0] oTag,
   output logic [63:0]      oResult,
`ifdef FP_RND_FLAG_ACC_EN
   input  logic             iFlagClr,
   output logic [4:0]       oFlagAcc,
`endif
   output logic [4:0]       oFlags
);

   // Handshake: a transfer happens on a clock edge where valid and ready are
   // both high (iValid&oReady at the input, oValid&iReady at the output).
   // Once oValid is high, oTag/oResult/oFlags hold until iReady accepts them.
   // A stage advances when it is empty or when the stage after it advances,
   // so input and output may transfer in the same cycle.

   // ---------------- stage 1 registers ----------------
   logic             s1_valid;
   logic [TAG_W-1:0] s1_tag;
   logic             s1_sig;
   logic [13:0]      s1_expo;
   logic [54:0]      s1_mant;
   logic             s1_dbl;
   logic [2:0]       s1_rm;
   logic             s1_inexact;
   logic [4:0]       s1_spc;   // {snan, qnan, dbz, infs, zero}

   logic s2_adv;
   logic s1_adv;

   assign s2_adv = ~oValid | iReady;
   assign s1_adv = s1_valid & s2_adv;
   assign oReady = ~s1_valid | s1_adv;

   // ---------------- stage 1 logic: rounding increment ----------------
   logic [2:0]  rm_eff;
   logic        rnd_c;
   logic [54:0] mant_r_c;

   assign rm_eff = (iRm > 3'd4) ? 3'd0 : iRm;

   always_comb begin
      rnd_c = 1'b0;
      case (rm_eff)
         3'd0:    rnd_c = iGrs[2] & (iMant[0] | iGrs[1] | iGrs[0]);
         3'd1:    rnd_c = 1'b0;
         3'd2:    rnd_c = iSig & (|iGrs);
         3'd3:    rnd_c = ~iSig & (|iGrs);
         3'd4:    rnd_c = iGrs[2];
         default: rnd_c = 1'b0;
      endcase
   end

   assign mant_r_c = {1'b0, iMant} + 55'(rnd_c);

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         s1_valid   <= 1'b0;
         s1_tag     <= '0;
         s1_sig     <= 1'b0;
         s1_expo    <= '0;
         s1_mant    <= '0;
         s1_dbl     <= 1'b0;
         s1_rm      <= '0;
         s1_inexact <= 1'b0;
         s1_spc     <= '0;
      end else if (oReady) begin
         s1_valid <= iValid;
         if (iValid) begin
            s1_tag     <= iTag;
            s1_sig     <= iSig;
            s1_expo    <= iExpo;
            s1_mant    <= mant_r_c;
            s1_dbl     <= (iFmt == 2'd1);
            s1_rm      <= rm_eff;
            s1_inexact <= |iGrs;
            s1_spc     <= {iSnan, iQnan, iDbz, iInfs, iZero};
         end
      end
   end

   // ---------------- stage 2 logic: renormalise, classify, pack ----------------
   logic        carry;
   logic [54:0] mant_n;
   logic [14:0] expo_n;
   logic        ovf;
   logic        udf;
   logic        to_inf;
   logic [63:0] nan_v, inf_v, zero_v, max_v;
   logic [63:0] res_c;
   logic [4:0]  flg_c;

   // Rounding up an all-ones mantissa carries one place past the hidden bit.
   assign carry  = s1_dbl ? s1_mant[53] : s1_mant[24];
   assign mant_n = carry ? (s1_mant >> 1) : s1_mant;
   assign expo_n = {1'b0, s1_expo} + 15'(carry);
   assign ovf    = s1_dbl ? (expo_n >= 15'd2047) : (expo_n >= 15'd255);
   // No subnormal support: a nonzero value with exponent 0 flushes to zero.
   assign udf    = (expo_n == 15'd0) && (|mant_n);

   // Overflow goes to infinity unless the rounding direction points toward
   // zero for this sign, in which case the largest finite value is returned.
   assign to_inf = (s1_rm == 3'd0) || (s1_rm == 3'd4) ||
                   ((s1_rm == 3'd3) && !s1_sig) || ((s1_rm == 3'd2) && s1_sig);

   assign nan_v  = s1_dbl ? 64'h7FF8000000000000 : 64'hFFFFFFFF7FC00000;
   assign inf_v  = s1_dbl ? {s1_sig, 11'h7FF, 52'd0} : {32'hFFFFFFFF, s1_sig, 8'hFF, 23'd0};
   assign zero_v = s1_dbl ? {s1_sig, 63'd0} : {32'hFFFFFFFF, s1_sig, 31'd0};
   assign max_v  = s1_dbl ? {s1_sig, 63'h7FEFFFFFFFFFFFFF} : {32'hFFFFFFFF, s1_sig, 31'h7F7FFFFF};

   always_comb begin
      res_c = '0;
      flg_c = '0;
      if (s1_spc[4]) begin
         res_c = nan_v;
         flg_c = 5'b10000;
      end else if (s1_spc[3]) begin
         res_c = nan_v;
      end else if (s1_spc[2]) begin
         res_c = inf_v;
         flg_c = 5'b01000;
      end else if (s1_spc[1]) begin
         res_c = inf_v;
      end else if (s1_spc[0]) begin
         res_c = zero_v;
      end else if (ovf) begin
         res_c = to_inf ? inf_v : max_v;
         flg_c = 5'b00101;
      end else if (udf) begin
         res_c = zero_v;
         flg_c = 5'b00011;
      end else begin
         if (s1_dbl) res_c = {s1_sig, expo_n[10:0], mant_n[51:0]};
         else        res_c = {32'hFFFFFFFF, s1_sig, expo_n[7:0], mant_n[22:0]};
         flg_c = {4'b0000, s1_inexact};
      end
   end

   // ---------------- stage 2 / output registers ----------------
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         oValid  <= 1'b0;
         oTag    <= '0;
         oResult <= '0;
         oFlags  <= '0;
      end else if (s2_adv) begin
         oValid <= s1_valid;
         if (s1_valid) begin
            oTag    <= s1_tag;
            oResult <= res_c;
            oFlags  <= flg_c;
         end
      end
   end

`ifdef FP_RND_FLAG_ACC_EN
   // Clear wins over the old contents but not over a transfer in the same
   // cycle: that transfer's flags become the new accumulated value.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         oFlagAcc <= '0;
      end else if (iFlagClr) begin
         oFlagAcc <= (oValid & iReady) ? oFlags : 5'd0;
      end else if (oValid & iReady) begin
         oFlagAcc <= oFlagAcc | oFlags;
      end
   end
`endif

endmodule

// File: tb/tb_fp_rnd_pipe.sv
`timescale 1ns/1ps
module tb_fp_rnd_pipe;

   localparam int TAG_W = 4;
   localparam int EW    = TAG_W + 64 + 5;

   logic             iClk = 1'b0;
   logic             iRst;
   logic             iValid;
   logic             oReady;
   logic [TAG_W-1:0] iTag;
   logic             iSig;
   logic [13:0]      iExpo;
   logic [53:0]      iMant;
   logic [1:0]       iFmt;
   logic [2:0]       iRm;
   logic [2:0]       iGrs;
   logic             iSnan, iQnan, iDbz, iInfs, iZero;
   logic             oValid;
   logic             iReady;
   logic [TAG_W-1:0] oTag;
   logic [63:0]      oResult;
   logic [4:0]       oFlags;
`ifdef FP_RND_FLAG_ACC_EN
   logic             iFlagClr;
   logic [4:0]       oFlagAcc;
`endif

   int tests_run    = 0;
   int tests_failed = 0;
   logic [EW-1:0] exp_q[$];

   fp_rnd_pipe #(.TAG_W(TAG_W)) dut (
`ifdef FP_RND_FLAG_ACC_EN
      .iFlagClr (iFlagClr),
      .oFlagAcc (oFlagAcc),
`endif
      .iClk    (iClk),
      .iRst    (iRst),
      .iValid  (iValid),
      .oReady  (oReady),
      .iTag    (iTag),
      .iSig    (iSig),
      .iExpo   (iExpo),
      .iMant   (iMant),
      .iFmt    (iFmt),
      .iRm     (iRm),
      .iGrs    (iGrs),
      .iSnan   (iSnan),
      .iQnan   (iQnan),
      .iDbz    (iDbz),
      .iInfs   (iInfs),
      .iZero   (iZero),
      .oValid  (oValid),
      .iReady  (iReady),
      .oTag    (oTag),
      .oResult (oResult),
      .oFlags  (oFlags)
   );

   // ---------------- clock ----------------
   always #5 iClk = ~iClk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // Returns {result, flags} for one transaction; spc = {snan,qnan,dbz,infs,zero}.
   function automatic logic [68:0] ref_model(input logic sig, input logic [13:0] expo,
                                             input logic [53:0] mant, input logic [1:0] fmt,
                                             input logic [2:0] rm, input logic [2:0] grs,
                                             input logic [4:0] spc);
      logic        dbl;
      logic [2:0]  r;
      logic        up, nx, g, rb, s;
      logic [54:0] m;
      int          e;
      logic [63:0] nan_v, inf_v, zero_v, max_v, res;
      dbl    = (fmt == 2'd1);
      r      = (rm > 3'd4) ? 3'd0 : rm;
      g      = grs[2];
      rb     = grs[1];
      s      = grs[0];
      nx     = g | rb | s;
      nan_v  = dbl ? 64'h7FF8000000000000 : 64'hFFFFFFFF7FC00000;
      inf_v  = dbl ? {sig, 11'h7FF, 52'd0} : {32'hFFFFFFFF, sig, 8'hFF, 23'd0};
      zero_v = dbl ? {sig, 63'd0} : {32'hFFFFFFFF, sig, 31'd0};
      max_v  = dbl ? {sig, 63'h7FEFFFFFFFFFFFFF} : {32'hFFFFFFFF, sig, 31'h7F7FFFFF};
      if (spc[4]) return {nan_v, 5'b10000};
      if (spc[3]) return {nan_v, 5'b00000};
      if (spc[2]) return {inf_v, 5'b01000};
      if (spc[1]) return {inf_v, 5'b00000};
      if (spc[0]) return {zero_v, 5'b00000};
      up = 1'b0;
      if (r == 3'd0)      up = g & (mant[0] | rb | s);
      else if (r == 3'd2) up = sig & nx;
      else if (r == 3'd3) up = ~sig & nx;
      else if (r == 3'd4) up = g;
      m = {1'b0, mant} + 55'(up);
      e = int'(expo);
      if (dbl ? m[53] : m[24]) begin
         m = m >> 1;
         e = e + 1;
      end
      if (e >= (dbl ? 2047 : 255)) begin
         if (r == 3'd0 || r == 3'd4 || (r == 3'd3 && !sig) || (r == 3'd2 && sig))
            return {inf_v, 5'b00101};
         return {max_v, 5'b00101};
      end
      if (e == 0 && m != 55'd0) return {zero_v, 5'b00011};
      if (dbl) res = {sig, e[10:0], m[51:0]};
      else     res = {32'hFFFFFFFF, sig, e[7:0], m[22:0]};
      return {res, 4'b0000, nx};
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge iClk) begin
      if (!iRst && oValid && iReady) begin
         logic [EW-1:0] exp_v;
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL sb_unexpected: got tag %0h result %h flags %b, required no output",
                     oTag, oResult, oFlags);
         end else begin
            exp_v = exp_q.pop_front();
            if ({oTag, oResult, oFlags} !== exp_v) begin
               tests_failed++;
               $display("FAIL sb_result: got tag %0h result %h flags %b, required tag %0h result %h flags %b",
                        oTag, oResult, oFlags, exp_v[EW-1 -: TAG_W], exp_v[68:5], exp_v[4:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [3:0] tag, input logic sig, input logic [13:0] expo,
                       input logic [53:0] mant, input logic [1:0] fmt, input logic [2:0] rm,
                       input logic [2:0] grs, input logic [4:0] spc, input logic [68:0] exp_rf);
      int budget = 0;
      iValid = 1'b1;
      iTag   = tag;
      iSig   = sig;
      iExpo  = expo;
      iMant  = mant;
      iFmt   = fmt;
      iRm    = rm;
      iGrs   = grs;
      {iSnan, iQnan, iDbz, iInfs, iZero} = spc;
      @(negedge iClk);
      while (!oReady && budget < 200) begin
         @(negedge iClk);
         budget++;
      end
      if (!oReady) begin
         tests_run++;
         tests_failed++;
         $display("FAIL send_timeout: oReady stayed %b, required 1", oReady);
         iValid = 1'b0;
         return;
      end
      exp_q.push_back({tag, exp_rf});
      @(posedge iClk);
      #1;
      iValid = 1'b0;
   endtask

   task automatic send_model(input logic [3:0] tag, input logic sig, input logic [13:0] expo,
                             input logic [53:0] mant, input logic [1:0] fmt, input logic [2:0] rm,
                             input logic [2:0] grs, input logic [4:0] spc);
      send(tag, sig, expo, mant, fmt, rm, grs, spc, ref_model(sig, expo, mant, fmt, rm, grs, spc));
   endtask

   task automatic drain();
      int budget = 0;
      iReady = 1'b1;
      while (exp_q.size() != 0 && budget < 100) begin
         @(posedge iClk);
         budget++;
      end
      @(posedge iClk);
      #1;
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic rand_txn(input logic [3:0] tag);
      logic [63:0] rbits;
      logic [4:0]  spc;
      logic [1:0]  fmt;
      rbits = {$urandom, $urandom};
      fmt   = 2'($urandom_range(0, 3));
      spc   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'd0;
      if (fmt == 2'd1)
         send_model(tag, 1'($urandom_range(0, 1)), 14'($urandom_range(0, 2050)),
                    {2'b01, rbits[51:0]}, fmt, 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), spc);
      else
         send_model(tag, 1'($urandom_range(0, 1)), 14'($urandom_range(0, 258)),
                    {30'd0, 1'b1, rbits[22:0]}, fmt, 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), spc);
   endtask

   // ---------------- test tasks ----------------
   task automatic test_reset();
      iRst = 1'b1;
      repeat (2) @(posedge iClk);
      #1;
      tests_run++;
      if (oValid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b, required 0", oValid); end
      tests_run++;
      if (oReady !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b, required 1", oReady); end
      tests_run++;
      if (oResult !== 64'd0 || oFlags !== 5'd0 || oTag !== 4'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got result %h flags %b tag %h, required zeros", oResult, oFlags, oTag);
      end
      iRst = 1'b0;
      @(posedge iClk);
      #1;
   endtask

   task automatic test_latency();
      iReady = 1'b1;
      send(4'h1, 1'b0, 14'd127, 54'h800000, 2'd0, 3'd0, 3'b000, 5'd0,
           {64'hFFFFFFFF3F800000, 5'b00000});
      tests_run++;
      if (oValid !== 1'b0) begin tests_failed++; $display("FAIL latency_early: oValid got %b, required 0", oValid); end
      @(posedge iClk);
      #1;
      tests_run++;
      if (oValid !== 1'b1 || oResult !== 64'hFFFFFFFF3F800000 || oFlags !== 5'd0) begin
         tests_failed++;
         $display("FAIL latency_two: got valid %b result %h flags %b, required 1 FFFFFFFF3F800000 00000",
                  oValid, oResult, oFlags);
      end
      drain();
   endtask

   task automatic test_rounding();
      iReady = 1'b1;
      send(4'h2, 1'b0, 14'd151, 54'h800000, 2'd0, 3'd0, 3'b100, 5'd0, {64'hFFFFFFFF4B800000, 5'b00001});
      send(4'h3, 1'b0, 14'd151, 54'h800000, 2'd0, 3'd3, 3'b100, 5'd0, {64'hFFFFFFFF4B800001, 5'b00001});
      send(4'h4, 1'b0, 14'd150, 54'hFFFFFF, 2'd0, 3'd0, 3'b100, 5'd0, {64'hFFFFFFFF4B800000, 5'b00001});
      send(4'h5, 1'b1, 14'd127, 54'h800000, 2'd0, 3'd2, 3'b011, 5'd0, {64'hFFFFFFFFBF800001, 5'b00001});
      send(4'h6, 1'b1, 14'd127, 54'h800001, 2'd0, 3'd1, 3'b111, 5'd0, {64'hFFFFFFFFBF800001, 5'b00001});
      send(4'h7, 1'b0, 14'd127, 54'h800000, 2'd0, 3'd4, 3'b100, 5'd0, {64'hFFFFFFFF3F800001, 5'b00001});
      send(4'h8, 1'b0, 14'd1023, 54'h10000000000000, 2'd1, 3'd0, 3'b000, 5'd0, {64'h3FF0000000000000, 5'b00000});
      // format 2 behaves as single, rounding mode 7 behaves as RNE
      send(4'h9, 1'b0, 14'd151, 54'h800000, 2'd2, 3'd7, 3'b110, 5'd0, {64'hFFFFFFFF4B800001, 5'b00001});
      drain();
   endtask

   task automatic test_overflow();
      iReady = 1'b1;
      send(4'hA, 1'b0, 14'd255, 54'h800000, 2'd0, 3'd0, 3'b000, 5'd0, {64'hFFFFFFFF7F800000, 5'b00101});
      send(4'hB, 1'b0, 14'd255, 54'h800000, 2'd0, 3'd1, 3'b000, 5'd0, {64'hFFFFFFFF7F7FFFFF, 5'b00101});
      send(4'hC, 1'b0, 14'd2047, 54'h10000000000000, 2'd1, 3'd2, 3'b000, 5'd0, {64'h7FEFFFFFFFFFFFFF, 5'b00101});
      send(4'hD, 1'b1, 14'd2047, 54'h10000000000000, 2'd1, 3'd2, 3'b000, 5'd0, {64'hFFF0000000000000, 5'b00101});
      send(4'hE, 1'b1, 14'd0, 54'h400000, 2'd0, 3'd0, 3'b000, 5'd0, {64'hFFFFFFFF80000000, 5'b00011});
      // rounding carry pushes exponent 254 to 255
      send(4'hF, 1'b0, 14'd254, 54'hFFFFFF, 2'd0, 3'd3, 3'b001, 5'd0, {64'hFFFFFFFF7F800000, 5'b00101});
      drain();
   endtask

   task automatic test_specials();
      iReady = 1'b1;
      send(4'h0, 1'b0, 14'd5, 54'h0, 2'd1, 3'd0, 3'b000, 5'b10000, {64'h7FF8000000000000, 5'b10000});
      send(4'h1, 1'b1, 14'd5, 54'h0, 2'd0, 3'd0, 3'b000, 5'b01000, {64'hFFFFFFFF7FC00000, 5'b00000});
      send(4'h2, 1'b1, 14'd5, 54'h0, 2'd0, 3'd0, 3'b000, 5'b00100, {64'hFFFFFFFFFF800000, 5'b01000});
      send(4'h3, 1'b0, 14'd5, 54'h0, 2'd1, 3'd1, 3'b000, 5'b00010, {64'h7FF0000000000000, 5'b00000});
      send(4'h4, 1'b1, 14'd5, 54'h0, 2'd1, 3'd0, 3'b111, 5'b00001, {64'h8000000000000000, 5'b00000});
      send(4'h5, 1'b0, 14'd5, 54'h0, 2'd0, 3'd0, 3'b111, 5'b11111, {64'hFFFFFFFF7FC00000, 5'b10000});
      send(4'h6, 1'b0, 14'd5, 54'h0, 2'd0, 3'd3, 3'b111, 5'b00110, {64'hFFFFFFFF7F800000, 5'b01000});
      drain();
   endtask

   task automatic test_back_to_back();
      iReady = 1'b1;
      fork
         begin
            for (int i = 0; i < 6; i++) rand_txn(4'(i + 8));
         end
         begin
            repeat (3) @(posedge iClk);
            #1;
            iReady = 1'b0;
            repeat (2) @(posedge iClk);
            @(negedge iClk);
            tests_run++;
            if (oReady !== 1'b0 || oValid !== 1'b1) begin
               tests_failed++;
               $display("FAIL stall_full: got oReady %b oValid %b, required 0 1", oReady, oValid);
            end
            @(posedge iClk);
            #1;
            iReady = 1'b1;
         end
      join
      drain();
   endtask

   task automatic test_random();
      bit done = 1'b0;
      fork
         begin
            for (int i = 0; i < 60; i++) rand_txn(4'(i));
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge iClk);
               #1;
               iReady = ($urandom_range(0, 3) != 0);
            end
         end
      join
      drain();
   endtask

   task automatic test_reset_midflight();
      iReady = 1'b0;
      send_model(4'h3, 1'b0, 14'd130, 54'hA00000, 2'd0, 3'd0, 3'b000, 5'd0);
      send_model(4'h4, 1'b0, 14'd131, 54'hB00000, 2'd0, 3'd0, 3'b000, 5'd0);
      @(posedge iClk);
      #2;
      iRst = 1'b1;
      #1;
      tests_run++;
      if (oValid !== 1'b0 || oReady !== 1'b1 || oResult !== 64'd0) begin
         tests_failed++;
         $display("FAIL reset_midflight: got valid %b ready %b result %h, required 0 1 0",
                  oValid, oReady, oResult);
      end
      exp_q.delete();
      @(posedge iClk);
      #1;
      iRst   = 1'b0;
      iReady = 1'b1;
      send(4'h9, 1'b0, 14'd128, 54'hC00000, 2'd0, 3'd0, 3'b000, 5'd0, {64'hFFFFFFFF40400000, 5'b00000});
      drain();
   endtask

`ifdef FP_RND_FLAG_ACC_EN
   task automatic test_flag_acc();
      iReady   = 1'b1;
      iFlagClr = 1'b1;
      @(posedge iClk);
      #1;
      iFlagClr = 1'b0;
      send(4'h1, 1'b0, 14'd151, 54'h800000, 2'd0, 3'd0, 3'b100, 5'd0, {64'hFFFFFFFF4B800000, 5'b00001});
      send(4'h2, 1'b0, 14'd255, 54'h800000, 2'd0, 3'd0, 3'b000, 5'd0, {64'hFFFFFFFF7F800000, 5'b00101});
      drain();
      tests_run++;
      if (oFlagAcc !== 5'b00101) begin
         tests_failed++;
         $display("FAIL flag_acc: got %b, required 00101", oFlagAcc);
      end
      iFlagClr = 1'b1;
      @(posedge iClk);
      #1;
      iFlagClr = 1'b0;
      tests_run++;
      if (oFlagAcc !== 5'b00000) begin
         tests_failed++;
         $display("FAIL flag_clr: got %b, required 00000", oFlagAcc);
      end
   endtask
`endif

   // ---------------- sequence ----------------
   initial begin
      iRst   = 1'b1;
      iValid = 1'b0;
      iReady = 1'b1;
      iTag   = '0;
      iSig   = 1'b0;
      iExpo  = '0;
      iMant  = '0;
      iFmt   = '0;
      iRm    = '0;
      iGrs   = '0;
      {iSnan, iQnan, iDbz, iInfs, iZero} = 5'd0;
`ifdef FP_RND_FLAG_ACC_EN
      iFlagClr = 1'b0;
`endif
      test_reset();
      test_latency();
      test_rounding();
      test_overflow();
      test_specials();
      test_back_to_back();
      test_random();
      test_reset_midflight();
`ifdef FP_RND_FLAG_ACC_EN
      test_flag_acc();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
